fft_twiddle_sequencer: RTL and testbench



---
 rtl/fft_twiddle_sequencer.sv | 138 +++++++++++++
 tb/tb_fft_twiddle_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_sequencer.sv
// fft_twiddle_sequencer: radix-2 DIF FFT butterfly scheduler emitting address pairs and twiddle indices
// with a valid/ready stream and a programmable drain gap between stages.
module fft_twiddle_sequencer #(
    parameter int LOG2N     = 7,
    parameter int STAGE_GAP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [2:0]       bf_stage,
    output logic [LOG2N-1:0] bf_addr_a,
    output logic [LOG2N-1:0] bf_addr_b,
    output logic [LOG2N-1:0] tw_idx,
    output logic             stage_last,
    output logic             frame_last
);
    localparam int               JW     = LOG2N - 1;
    localparam logic [JW-1:0]    J_LAST = '1;
    localparam logic [2:0]       S_LAST = 3'(LOG2N - 1);
    localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
    localparam logic [LOG2N-1:0] HALF   = ONE << JW;
    localparam logic [3:0]       GAP_LD = 4'(STAGE_GAP);

    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    state_t           state_q, state_d;
    logic [2:0]       s_q, s_d, stage_q, stage_d;
    logic [JW-1:0]    j_q, j_d;
    logic [3:0]       gap_q, gap_d;
    logic             busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic             sl_q, sl_d, fl_q, fl_d, run;
    logic [LOG2N-1:0] a_q, a_d, b_q, b_d, tw_q, tw_d, span, jj, p;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        gap_d   = gap_q;
        if (abort) begin
            state_d = IDLE;
            s_d     = '0;
            j_d     = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = RUN;
                    s_d     = '0;
                    j_d     = '0;
                end
                RUN: if (bf_ready) begin
                    if (j_q != J_LAST) j_d = j_q + JW'(1);
                    else if (s_q == S_LAST) begin
                        state_d = FIN;
                        s_d     = '0;
                        j_d     = '0;
                    end else if (STAGE_GAP > 0) begin
                        state_d = GAP;
                        j_d     = '0;
                        gap_d   = GAP_LD;
                    end else begin
                        s_d = s_q + 3'd1;
                        j_d = '0;
                    end
                end
                GAP: begin
                    gap_d = gap_q - 4'd1;
                    if (gap_q == 4'd1) begin
                        state_d = RUN;
                        s_d     = s_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Descriptor is precomputed from next-state counters so every output leaves a flop.
        run     = state_d == RUN;
        jj      = {1'b0, j_d};
        span    = HALF >> s_d;
        p       = jj & (span - ONE);
        a_d     = run ? (((jj & ~(span - ONE)) << 1) | p) : '0;
        b_d     = run ? (a_d | span) : '0;
        tw_d    = run ? (p << s_d) : '0;
        stage_d = run ? s_d : '0;
        sl_d    = run && (j_d == J_LAST);
        fl_d    = sl_d && (s_d == S_LAST);
        valid_d = run;
        busy_d  = state_d != IDLE;
        done_d  = state_d == FIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            gap_q   <= '0;
            stage_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tw_q    <= '0;
            sl_q    <= 1'b0;
            fl_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            gap_q   <= gap_d;
            stage_q <= stage_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tw_q    <= tw_d;
            sl_q    <= sl_d;
            fl_q    <= fl_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign bf_valid   = valid_q;
    assign bf_stage   = stage_q;
    assign bf_addr_a  = a_q;
    assign bf_addr_b  = b_q;
    assign tw_idx     = tw_q;
    assign stage_last = sl_q;
    assign frame_last = fl_q;
endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// tb_fft_twiddle_sequencer: scoreboard bench over three sequencer configurations
// (N=8 no gap, N=8 gap 4, N=128 gap 3).
module tb_fft_twiddle_sequencer;
    typedef struct packed {
        logic [2:0] stg;
        logic [6:0] a;
        logic [6:0] b;
        logic [6:0] tw;
        logic       sl;
        logic       fl;
    } desc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0, abort = '0, ready = '0;
    logic [2:0] busy, done, valid, sl, fl;
    logic [2:0] stg [3];
    logic [2:0] a0, b0, t0, a1, b1, t1;
    logic [6:0] a2, b2, t2;
    desc_t      act [3];

    desc_t exp_q [3][$];
    desc_t last_d [3];
    int    beats [3] = '{default: 0};
    int    hs_cyc [3] = '{default: 0};
    logic  exp_done [3] = '{default: 1'b0};
    int    n_chk = 0, n_fail = 0, cyc = 0;

    int ta [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int tb [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int tt [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_twiddle_sequencer #(.LOG2N(3), .STAGE_GAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .busy(busy[0]), .done(done[0]),
        .bf_valid(valid[0]), .bf_ready(ready[0]), .bf_stage(stg[0]), .bf_addr_a(a0), .bf_addr_b(b0),
        .tw_idx(t0), .stage_last(sl[0]), .frame_last(fl[0]));
    fft_twiddle_sequencer #(.LOG2N(3), .STAGE_GAP(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .busy(busy[1]), .done(done[1]),
        .bf_valid(valid[1]), .bf_ready(ready[1]), .bf_stage(stg[1]), .bf_addr_a(a1), .bf_addr_b(b1),
        .tw_idx(t1), .stage_last(sl[1]), .frame_last(fl[1]));
    fft_twiddle_sequencer #(.LOG2N(7), .STAGE_GAP(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .busy(busy[2]), .done(done[2]),
        .bf_valid(valid[2]), .bf_ready(ready[2]), .bf_stage(stg[2]), .bf_addr_a(a2), .bf_addr_b(b2),
        .tw_idx(t2), .stage_last(sl[2]), .frame_last(fl[2]));

    assign act[0] = {stg[0], 4'b0, a0, 4'b0, b0, 4'b0, t0, sl[0], fl[0]};
    assign act[1] = {stg[1], 4'b0, a1, 4'b0, b1, 4'b0, t1, sl[1], fl[1]};
    assign act[2] = {stg[2], a2, b2, t2, sl[2], fl[2]};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic r, input logic dn, input desc_t d);
        if (v && r) begin
            if (exp_q[k].size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_beat dut%0d: got %0h, want no beat", k, d);
            end else chk($sformatf("beat%0d_dut%0d", beats[k], k), 64'(d), 64'(exp_q[k].pop_front()));
            beats[k]++;
            last_d[k] = d;
            if (d.fl) begin
                exp_done[k] = 1'b1;
                hs_cyc[k]   = cyc;
            end
        end else if (v && exp_q[k].size() > 0) chk($sformatf("stall_hold_dut%0d", k), 64'(d), 64'(exp_q[k][0]));
        if (dn) begin
            chk($sformatf("done_pulse_dut%0d", k), 64'({exp_done[k], 32'(cyc - hs_cyc[k])}), 64'({1'b1, 32'd1}));
            exp_done[k] = 1'b0;
        end
    endtask

    always @(negedge clk) for (int k = 0; k < 3; k++) mon(k, valid[k], ready[k], done[k], act[k]);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int k);
        beats[k] = 0;
        step();
        start[k] = 1'b1;
        step();
        start[k] = 1'b0;
    endtask

    task automatic push_hand(input int k, input int cnt);
        desc_t e;
        for (int i = 0; i < cnt; i++) begin
            e = {3'(i / 4), 7'(ta[i]), 7'(tb[i]), 7'(tt[i]), (i % 4 == 3), (i == 11)};
            exp_q[k].push_back(e);
        end
    endtask

    // Reference DIF schedule enumerated group by group, independent of bit tricks.
    task automatic push_model(input int k, input int l);
        desc_t e;
        int n, span;
        n = 1 << l;
        for (int s = 0; s < l; s++) begin
            span = n >> (s + 1);
            for (int g = 0; g < n / (2 * span); g++)
                for (int q = 0; q < span; q++) begin
                    e.stg = 3'(s);
                    e.a   = 7'(g * 2 * span + q);
                    e.b   = 7'(g * 2 * span + q + span);
                    e.tw  = 7'(q * (1 << s));
                    e.sl  = (g * span + q) == (n / 2 - 1);
                    e.fl  = e.sl && (s == l - 1);
                    exp_q[k].push_back(e);
                end
        end
    endtask

    task automatic wait_done(input int k, input int budget, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done[k];
        end
        chk(name, 64'(seen), 64'(1));
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] vrec, drec;
        logic [20:0] v2, d2, bz;
        logic        seen;
        ready = 3'b011;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_outputs_dut%0d", k), 64'({busy[k], done[k], valid[k], act[k]}), 64'(0));
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // N=8, no gap: 12 back-to-back beats; start mid-frame and in FIN ignored
        push_hand(0, 12);
        start_frame(0);
        vrec = '0;
        drec = '0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            vrec = {vrec[11:0], valid[0]};
            drec = {drec[11:0], done[0]};
            start[0] = (i == 5) || (i == 12);
        end
        step();
        start[0] = 1'b0;
        chk("nogap_valid_pattern", 64'(vrec), 64'(13'b1111111111110));
        chk("nogap_done_pattern", 64'(drec), 64'(13'b0000000000001));
        @(negedge clk);
        chk("nogap_idle_after", 64'({busy[0], valid[0]}), 64'(0));
        chk("nogap_beats", 64'(beats[0]), 64'(12));
        chk("nogap_queue_empty", 64'(exp_q[0].size()), 64'(0));

        // start together with abort in IDLE stays idle
        step();
        start[0] = 1'b1;
        abort[0] = 1'b1;
        step();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", 64'({busy[0], valid[0]}), 64'(0));

        // N=8, gap 4: four invalid cycles after each non-final stage, 20-cycle span
        push_hand(1, 12);
        start_frame(1);
        v2 = '0;
        d2 = '0;
        bz = '0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            v2 = {v2[19:0], valid[1]};
            d2 = {d2[19:0], done[1]};
            bz = {bz[19:0], busy[1]};
        end
        chk("gap_valid_pattern", 64'(v2), 64'(21'b111100001111000011110));
        chk("gap_done_pattern", 64'(d2), 64'(21'b1));
        chk("gap_busy_pattern", 64'(bz), 64'(21'h1FFFFF));
        chk("gap_beats", 64'(beats[1]), 64'(12));

        // abort on beat 6, no done, then clean restart
        push_hand(0, 6);
        start_frame(0);
        repeat (6) @(negedge clk);
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        @(negedge clk);
        chk("abort_idle", 64'({busy[0], valid[0]}), 64'(0));
        chk("abort_beats", 64'(beats[0]), 64'(6));
        repeat (4) @(negedge clk);
        chk("abort_no_done_pending", 64'(exp_done[0]), 64'(0));
        push_hand(0, 12);
        start_frame(0);
        wait_done(0, 40, "restart_done");
        chk("restart_beats", 64'(beats[0]), 64'(12));

        // N=128 with random ready against the reference model
        push_model(2, 7);
        start_frame(2);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            step();
            ready[2] = 1'($urandom_range(0, 1));
            @(negedge clk);
            seen = done[2];
        end
        ready[2] = 1'b1;
        chk("n128_done", 64'(seen), 64'(1));
        chk("n128_beats", 64'(beats[2]), 64'(448));
        chk("n128_last", 64'(last_d[2]), 64'({3'd6, 7'd126, 7'd127, 7'd0, 1'b1, 1'b1}));

        // asynchronous reset in the middle of a gap
        push_hand(1, 4);
        start_frame(1);
        repeat (5) @(negedge clk);
        chk("in_gap", 64'({busy[1], valid[1]}), 64'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({busy[1], done[1], valid[1], act[1]}), 64'(0));
        chk("async_reset_beats", 64'(beats[1]), 64'(4));
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", 64'({busy[1], valid[1], done[1]}), 64'(0));
        push_hand(1, 12);
        start_frame(1);
        wait_done(1, 60, "post_reset_done");
        chk("post_reset_beats", 64'(beats[1]), 64'(12));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
